line_mem_arbiter: RTL and testbench
===================================

# line_mem_arbiter

Shares the single physical memory port between the instruction cache and the data cache of the pipelined RV32I core. The block accepts at most one line-sized miss transaction at a time and forwards it to physical memory. It returns the response to the winning cache only. Its `i_resp`/`d_resp` outputs feed the `instr_mem_resp`/`data_mem_resp` inputs of the stalling logic, so arbitration directly determines which pipeline stages are held.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width.
- `LINE_W`, 256: cache line width in bits.
- `CNT_W`, 32: width of the per-requester grant counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset. Asserting `rst` low resets the block immediately; release is synchronous to `clk`.
- `i_read` in 1: I-cache line read request.
- `i_address` in ADDR_W: I-cache line address.
- `i_rdata` out LINE_W: line returned to the I-cache.
- `i_resp` out 1: I-cache transaction complete.
- `d_read` in 1: D-cache line read request.
- `d_write` in 1: D-cache line write-back request.
- `d_address` in ADDR_W: D-cache line address.
- `d_wdata` in LINE_W: D-cache write-back data.
- `d_rdata` out LINE_W: line returned to the D-cache.
- `d_resp` out 1: D-cache transaction complete.
- `pmem_read` out 1, `pmem_write` out 1: physical memory command.
- `pmem_address` out ADDR_W: physical memory address.
- `pmem_wdata` out LINE_W: physical memory write data.
- `pmem_rdata` in LINE_W: physical memory read data.
- `pmem_resp` in 1: physical memory transaction complete.
- `i_grants` out CNT_W: count of completed I-side transactions.
- `d_grants` out CNT_W: count of completed D-side transactions.

## Operation
- **States:** IDLE, SERVE_I, SERVE_D.
- **Reset values:** state = IDLE, `last_grant` = I, all grant counters = 0, all outputs = 0.
- **IDLE, single requester:** a D request (`d_read|d_write`) goes to SERVE_D. An `i_read` alone goes to SERVE_I. With no request, stay in IDLE.
- **IDLE, both pending:** winner is chosen per Configuration.
- **Latching on grant:** the winner's address, command and write data are latched into `addr_q`, `cmd_q` and `wdata_q`. `last_grant` updates to the winner.
- **`d_read` and `d_write` both high:** treated as a write. A read is never issued for that request.
- **In SERVE_x:** `pmem_read`/`pmem_write` are driven from `cmd_q`. `pmem_address` = `addr_q`; `pmem_wdata` = `wdata_q`.
- **Completion:** on `pmem_resp`=1 in SERVE_x, the block pulses `x_resp` high for exactly that cycle. `x_rdata` = `pmem_rdata`, passed through combinationally. The counter `x_grants` increments (wraps modulo 2^CNT_W), and the next state is IDLE.
- **`pmem_resp` while in IDLE:** ignored.
- **Loser request:** held pending with its `x_resp` low. The requester must hold its request until `x_resp`.
- **Request dropped mid-transaction:** if the winner drops its request before `pmem_resp`, the transaction still completes and `x_resp` still pulses.
- **rdata outside completion:** `i_rdata`/`d_rdata` read 0 whenever the corresponding `x_resp` is 0.

## Timing
- **Grant latency:** a request seen in IDLE at edge N puts the pmem command on the port starting in cycle N+1.
- **Completion:** `x_resp` is asserted in the same cycle as `pmem_resp`, with no added latency.
- **Bubble:** there is a mandatory one-cycle IDLE bubble between back-to-back transactions. Minimum transaction occupancy is 2 cycles plus memory latency.
- **Command hold:** pmem command/address/data are held stable from grant until `pmem_resp`.
- **Reset mid-transaction:** `pmem_read`/`pmem_write` drop asynchronously, the in-flight transaction is abandoned, and no `x_resp` is issued.

## Configuration
- **Macro:** `ARB_ROUND_ROBIN_EN`.
- **Defined:** when both caches are pending in IDLE, the grant goes to the requester that is not `last_grant`. Because reset sets `last_grant` = I, the first contention goes to D and the next goes to I.
- **Undefined:** fixed priority; D always wins contention and I waits until no D request is pending in IDLE. `last_grant` is still maintained but unused.

## Test plan
- **Lone I-read:** `i_read`=1 at `i_address`=0x0000_0040, memory responds 3 cycles after the command with rdata=0xA5…A5 -> `pmem_read`=1 with `pmem_address`=0x40 from cycle 1. `i_resp` is a 1-cycle pulse with `i_rdata`=0xA5…A5, and `i_grants`=1.
- **Lone D-write:** `d_write`=1 at 0x1000, `d_wdata`=0x1234 -> `pmem_write`=1, `pmem_wdata`=0x1234, `d_resp` pulses, `pmem_read` never rises, `d_grants`=1.
- **Simultaneous requests:** `i_read`=1 and `d_read`=1 in the same cycle, held for 4 back-to-back contentions.
  - With macro: grant order D,I,D,I.
  - Without macro: D is granted repeatedly while `d_read` is held. I is granted only once D drops.
- **Both read and write:** `d_read`=`d_write`=1 -> only `pmem_write` asserted.
- **Reset mid-transaction:** `rst` driven low 2 cycles into SERVE_D, before `pmem_resp` -> `pmem_write` falls the same cycle without waiting for `clk`. No `d_resp`, counters = 0, state IDLE after release.
- **Counter wrap:** with CNT_W=4, run 16 I-transactions -> `i_grants` wraps to 0.

Source files
------------

// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: shares the physical memory port between I-cache and D-cache line misses.
// Define ARB_ROUND_ROBIN_EN to alternate contention grants; the default is fixed D-over-I priority.
module line_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [CNT_W-1:0]  i_grants,
  output logic [CNT_W-1:0]  d_grants
);

  // state   | meaning
  // IDLE    | nothing in flight; arbitrate pending requests
  // SERVE_I | I-cache line read in flight on pmem
  // SERVE_D | D-cache line read or write-back in flight on pmem
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit FIXED_PRI = 1'b0;
`else
  localparam bit FIXED_PRI = 1'b1;
`endif

  state_t              state;
  logic                last_grant_d;
  logic                cmd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic                d_req;
  logic                grant_d;
  logic                serving;

  assign d_req = d_read | d_write;

  // With fixed priority last_grant_d drops out of the grant term.
  assign grant_d = d_req & (~i_read | ~last_grant_d | FIXED_PRI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      cmd_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_grants     <= '0;
      d_grants     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state        <= SERVE_D;
            cmd_q        <= d_write;
            addr_q       <= d_address;
            wdata_q      <= d_wdata;
            last_grant_d <= 1'b1;
          end else if (i_read) begin
            state        <= SERVE_I;
            cmd_q        <= 1'b0;
            addr_q       <= i_address;
            wdata_q      <= '0;
            last_grant_d <= 1'b0;
          end
        end
        SERVE_I: begin
          if (pmem_resp) begin
            state    <= IDLE;
            i_grants <= i_grants + CNT_W'(1);
          end
        end
        SERVE_D: begin
          if (pmem_resp) begin
            state    <= IDLE;
            d_grants <= d_grants + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // cmd_q is the write flag: a D request with d_write set never issues a read.
  assign serving      = (state != IDLE);
  assign pmem_read    = serving & ~cmd_q;
  assign pmem_write   = serving & cmd_q;
  assign pmem_address = serving ? addr_q : '0;
  assign pmem_wdata   = serving ? wdata_q : '0;

  assign i_resp  = (state == SERVE_I) & pmem_resp;
  assign d_resp  = (state == SERVE_D) & pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// tb_line_mem_arbiter: directed and randomized checks of line_mem_arbiter against a transaction-level model.
// Build with or without ARB_ROUND_ROBIN_EN; expected contention order follows the same macro.
module tb_line_mem_arbiter;
  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 256;
  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_address = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_address = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;
  logic [CNT_W-1:0]  i_grants;
  logic [CNT_W-1:0]  d_grants;

  line_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .i_grants(i_grants), .d_grants(d_grants)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Transaction-level model: one outstanding transfer, who won it, and completion totals.
  bit                m_busy = 0;
  bit                m_side_d = 0;
  bit                m_write = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [LINE_W-1:0] m_wdata = '0;
  bit                m_last_d = 0;
  int                m_cnt_i = 0;
  int                m_cnt_d = 0;

  function automatic bit pick_d(input bit want_i, input bit want_d, input bit last_d);
    if (!want_d) return 1'b0;
    if (!want_i) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy  <= 0;
      m_last_d <= 0;
      m_cnt_i <= 0;
      m_cnt_d <= 0;
    end else if (m_busy) begin
      if (pmem_resp) begin
        m_busy <= 0;
        if (m_side_d) m_cnt_d <= m_cnt_d + 1;
        else          m_cnt_i <= m_cnt_i + 1;
      end
    end else if (i_read || d_read || d_write) begin
      m_busy <= 1;
      if (pick_d(i_read, d_read | d_write, m_last_d)) begin
        m_side_d <= 1; m_write <= d_write; m_addr <= d_address; m_wdata <= d_wdata; m_last_d <= 1;
      end else begin
        m_side_d <= 0; m_write <= 0; m_addr <= i_address; m_wdata <= '0; m_last_d <= 0;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_ir, exp_dr;
    exp_ir = m_busy && !m_side_d && pmem_resp;
    exp_dr = m_busy && m_side_d && pmem_resp;
    chk("pmem_read", pmem_read, m_busy && !m_write);
    chk("pmem_write", pmem_write, m_busy && m_write);
    if (m_busy) begin
      chk("pmem_address", pmem_address, m_addr);
      chk("pmem_wdata", pmem_wdata, m_wdata);
    end
    chk("i_resp", i_resp, exp_ir);
    chk("d_resp", d_resp, exp_dr);
    chk("i_rdata", i_rdata, exp_ir ? pmem_rdata : '0);
    chk("d_rdata", d_rdata, exp_dr ? pmem_rdata : '0);
    chk("i_grants", i_grants, LINE_W'(m_cnt_i % CNT_MOD));
    chk("d_grants", d_grants, LINE_W'(m_cnt_d % CNT_MOD));
  end

  // Memory responder and requester stimulus.
  bit                rand_mode = 0;
  int                fixed_lat = 0;
  int                mem_lat = 0;
  bit                mem_active = 0;
  logic [LINE_W-1:0] resp_data = '0;
  logic              i_resp_s, d_resp_s;
  logic [LINE_W-1:0] i_rdata_s, d_rdata_s;

  task automatic mem_step();
    logic cmd;
    cmd = pmem_read | pmem_write;
    pmem_rdata = rand_line();
    if (pmem_resp) pmem_resp = 1'b0;
    else if (cmd) begin
      if (!mem_active) begin
        mem_active = 1;
        mem_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
      end
      if (mem_lat == 0) begin
        pmem_resp = 1'b1;
        mem_active = 0;
        if (!rand_mode) pmem_rdata = resp_data;
      end else mem_lat--;
    end else if (rand_mode && $urandom_range(0, 7) == 0) pmem_resp = 1'b1;
  endtask

  task automatic req_step();
    int k;
    if (i_read) begin
      if (i_resp_s || $urandom_range(0, 31) == 0) i_read = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      i_read = 1'b1; i_address = $urandom;
    end
    if (d_read || d_write) begin
      if (d_resp_s || $urandom_range(0, 31) == 0) begin d_read = 1'b0; d_write = 1'b0; end
    end else if ($urandom_range(0, 2) == 0) begin
      k = int'($urandom_range(0, 2));
      d_read = (k != 1); d_write = (k != 0);
      d_address = $urandom; d_wdata = rand_line();
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    i_resp_s = i_resp; d_resp_s = d_resp; i_rdata_s = i_rdata; d_rdata_s = d_rdata;
    @(posedge clk);
    #1;
    mem_step();
    if (rand_mode) req_step();
  endtask

  task automatic wait_resp(output bit got_d, output logic [LINE_W-1:0] rd);
    got_d = 0; rd = '0;
    for (int n = 0; n < 40; n++) begin
      cycle();
      if (i_resp_s || d_resp_s) begin
        got_d = d_resp_s;
        rd = d_resp_s ? d_rdata_s : i_rdata_s;
        return;
      end
    end
    vectors++; miscompares++;
    $display("FAIL wait_resp: no response within 40 cycles at %0t", $time);
  endtask

  task automatic do_reset();
    rst = 1'b0; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0; mem_active = 0;
    #4;
    chk("reset_pmem_read", pmem_read, 0);
    chk("reset_pmem_write", pmem_write, 0);
    chk("reset_i_resp", i_resp, 0);
    chk("reset_d_resp", d_resp, 0);
    chk("reset_i_grants", i_grants, 0);
    chk("reset_d_grants", d_grants, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  task automatic lone_i(input logic [ADDR_W-1:0] a);
    bit gd;
    logic [LINE_W-1:0] rd;
    i_read = 1'b1; i_address = a;
    wait_resp(gd, rd);
    i_read = 1'b0;
    chk("lone_i_side", gd, 0);
  endtask

  initial begin
    bit gd;
    logic [LINE_W-1:0] rd;
    logic [LINE_W-1:0] a5;
    bit exp_order [4];
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    a5 = {32{8'hA5}};
    #2;
    do_reset();

    // lone I-read: command one cycle after grant, pulse carries memory data
    fixed_lat = 3; resp_data = a5;
    i_read = 1'b1; i_address = 32'h0000_0040;
    cycle();
    chk("lone_i_pmem_read", pmem_read, 1);
    chk("lone_i_pmem_address", pmem_address, 32'h40);
    wait_resp(gd, rd);
    i_read = 1'b0;
    chk("lone_i_side", gd, 0);
    chk("lone_i_rdata", rd, a5);
    chk("lone_i_grants", i_grants, 1);

    // lone D-write
    d_write = 1'b1; d_address = 32'h1000; d_wdata = 256'h1234;
    cycle();
    chk("lone_d_pmem_write", pmem_write, 1);
    chk("lone_d_pmem_read", pmem_read, 0);
    chk("lone_d_pmem_wdata", pmem_wdata, 256'h1234);
    wait_resp(gd, rd);
    d_write = 1'b0;
    chk("lone_d_side", gd, 1);
    chk("lone_d_grants", d_grants, 1);

    // read and write together is a write
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h2000; d_wdata = 256'h77;
    cycle();
    chk("rw_pmem_write", pmem_write, 1);
    chk("rw_pmem_read", pmem_read, 0);
    wait_resp(gd, rd);
    d_read = 1'b0; d_write = 1'b0;
    chk("rw_d_grants", d_grants, 2);

    // contention from a fresh reset
    do_reset();
    fixed_lat = 1;
    i_read = 1'b1; i_address = 32'h100;
    d_read = 1'b1; d_address = 32'h200;
    for (int k = 0; k < 4; k++) begin
      wait_resp(gd, rd);
      chk($sformatf("contention_%0d_side_d", k), gd, exp_order[k]);
    end
    d_read = 1'b0;
    wait_resp(gd, rd);
    chk("contention_after_d_drop", gd, 0);
    i_read = 1'b0;

    // asynchronous reset during a D write-back
    fixed_lat = 20;
    d_write = 1'b1; d_address = 32'h3000; d_wdata = 256'h55;
    cycle();
    cycle();
    chk("rst_mid_before", pmem_write, 1);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_mid_pmem_write_async", pmem_write, 0);
    chk("rst_mid_d_resp", d_resp, 0);
    d_write = 1'b0; pmem_resp = 1'b0; mem_active = 0;
    @(posedge clk);
    #2;
    chk("rst_mid_i_grants", i_grants, 0);
    chk("rst_mid_d_grants", d_grants, 0);
    #1;
    rst = 1'b1;
    cycle();
    chk("rst_mid_idle_after", pmem_write, 0);

    // 4-bit counter wraps after 16 completions
    fixed_lat = 0;
    lone_i(32'h40);
    chk("wrap_first", i_grants, 1);
    for (int k = 1; k < 16; k++) lone_i(32'h40 + 32'(k) * 32'h20);
    chk("wrap_i_grants", i_grants, 0);
    chk("wrap_model_count", LINE_W'(m_cnt_i), 16);

    // randomized traffic against the model
    rand_mode = 1; fixed_lat = -1;
    repeat (4000) cycle();
    rand_mode = 0;
    i_read = 0; d_read = 0; d_write = 0;
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
